mmio_bridge: RTL
================

Name: mmio_bridge

Overview:
- Sits directly downstream of the CPU core's byte-wide memory bus (address, dout, din, wr, io_buffer_full).
- Routes each access either to the 128 KB RAM or to the I/O space (addr[17:16]==2'b11).
- Owns the UART TX FIFO, the RX byte pop, the cycle counter at 0x30004 and the program-stop flag.
- Drives io_buffer_full back to the core.

Parameters:
- TX_DEPTH, 16, UART TX FIFO entries (power of 2, >=4)
- FULL_MARGIN, 4, io_buffer_full asserts when occupancy >= TX_DEPTH-FULL_MARGIN
- RAM_AW, 17, RAM byte-address width

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset
- rdy_in  in  1  global ready; bridge frozen when low
- cpu_a  in  32  CPU address bus
- cpu_wr  in  1  1=write, 0=read
- cpu_dout  in  8  write data from CPU
- cpu_din  out  8  read data to CPU
- io_buffer_full  out  1  TX FIFO near-full to CPU
- ram_a  out  RAM_AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, valid one cycle after address
- tx_data  out  8  UART TX byte
- tx_valid  out  1  TX byte valid
- tx_ready  in  1  UART accepts byte when tx_valid&&tx_ready
- rx_data  in  8  UART RX head byte
- rx_empty  in  1  RX FIFO empty
- rx_pop  out  1  pop RX head (1-cycle pulse)
- program_finish  out  1  sticky; stop written and TX drained

Behaviour:
- One clock: clk_in. Reset is synchronous, active-high: rst_in sampled on the rising edge of clk_in.
- Reset values: cpu_din=0, io_buffer_full=0, ram_we=0, tx_valid=0, rx_pop=0, program_finish=0; FIFO empty, counter=0, snapshot=0, stop_pending=0, overflow=0.
- rdy_in low:
  - all state holds, including counter, FIFO pointers and snapshot.
  - ram_we, rx_pop and TX handshake are forced 0.
- Decode (combinational): is_io = cpu_a[17:16]==2'b11. RAM side: ram_a=cpu_a[RAM_AW-1:0], ram_wdata=cpu_dout, ram_we=cpu_wr&&!is_io&&rdy_in.
- Read latency is 1 cycle for every target.
  - Register sel (RAM / RX / CNT0..CNT3 / ZERO) at access.
  - cpu_din muxes on registered sel: RAM->ram_rdata; RX->latched rx byte; CNTk->snapshot[8k+7:8k].
- 0x30000 read:
  - rx_empty=0 -> rx_pop pulses 1 cycle; byte latched; returned next cycle.
  - rx_empty=1 -> no pop; returns 0x00.
- 0x30004 read: snapshot<=counter, return byte0. Reads of 0x30005..0x30007 return snapshot bytes 1..3 with no re-snapshot.
- Counter: 32-bit, +1 every cycle with rdy_in high; wraps 0xFFFFFFFF->0.
- 0x30000 write:
  - data==0x00 -> ignored.
  - else push to TX FIFO.
  - FIFO full -> byte dropped, overflow flag set (sticky; debug only).
- 0x30004 write: push 0x00 (bypasses zero filter, same full rule); set stop_pending.
- program_finish<=1 when stop_pending && FIFO empty && !tx_valid. Stays 1 until reset.
- Other I/O addresses: reads return 0, writes ignored.
- TX FIFO:
  - circular, count width log2(TX_DEPTH)+1; head/tail wrap modulo TX_DEPTH.
  - tx_valid = !empty; tx_data = head entry.
  - Pop on tx_valid&&tx_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance. Legal when full: the pop frees the slot, no drop.
- io_buffer_full is registered from next-state count (count_next >= TX_DEPTH-FULL_MARGIN), so it reflects the current cycle's push.
- Reset mid-operation: FIFO contents discarded; pending read data lost, cpu_din=0 next cycle.

Optional Feature:
- Macro: MMIO_TX_STATS_EN.
- With the macro: a 32-bit accepted-TX-byte counter (including the stop 0x00, excluding dropped bytes).
  - Read 0x30008 snapshots it and returns byte0.
  - 0x30009..0x3000B return bytes 1..3.
  - The overflow flag is readable as bit0 of 0x3000C.
- Without the macro: 0x30008..0x3000C read 0x00 as unmapped; no counter logic is synthesised.

Test Plan:
- RAM: write 0x5A to 0x00100, then read 0x00100 -> ram_we pulses once; cpu_din=0x5A exactly one cycle after the read address.
- TX filtering: write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx sequence 0x41, 0x42 only; the 0x00 is never pushed.
- Near-full: TX_DEPTH=16, tx_ready=0, write 12 nonzero bytes -> io_buffer_full=1 the cycle after the 12th write.
  - 4 more writes fill the FIFO; a 17th write is dropped and sets overflow.
  - Raise tx_ready -> exactly 16 bytes emitted.
- Counter: reset, 100 cycles rdy_in=1, 10 cycles rdy_in=0, then read 0x30004..0x30007 -> snapshot 100 (0x64,0x00,0x00,0x00). Bytes unchanged across the 4 reads despite counting.
- Stop: 3 bytes queued, tx_ready=0, write 0x30004 -> program_finish stays 0; raise tx_ready -> 4 bytes out (last 0x00), program_finish=1 the cycle after the FIFO empties, held until rst_in.
- RX: rx_empty=0, rx_data=0x37, read 0x30000 -> rx_pop one cycle, cpu_din=0x37. Then rx_empty=1, read -> no pop, cpu_din=0x00.

Source files
------------

// File: rtl/mmio_bridge_if.sv
// CPU-side, RAM-side and UART-side signal bundle of the MMIO bridge.
// The bridge connects through the slave modport and its environment through the master modport.
interface mmio_bridge_if #(
  parameter int RAM_AW = 17
);
  logic [31:0]       cpu_a;
  logic              cpu_wr;
  logic [7:0]        cpu_dout;
  logic [7:0]        cpu_din;
  logic              io_buffer_full;
  logic [RAM_AW-1:0] ram_a;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_data;
  logic              rx_empty;
  logic              rx_pop;
  logic              program_finish;
  logic              dbg_overflow;

  modport slave (
    input  cpu_a, cpu_wr, cpu_dout, ram_rdata, tx_ready, rx_data, rx_empty,
    output cpu_din, io_buffer_full, ram_a, ram_we, ram_wdata, tx_data, tx_valid,
           rx_pop, program_finish, dbg_overflow
  );

  modport master (
    output cpu_a, cpu_wr, cpu_dout, ram_rdata, tx_ready, rx_data, rx_empty,
    input  cpu_din, io_buffer_full, ram_a, ram_we, ram_wdata, tx_data, tx_valid,
           rx_pop, program_finish, dbg_overflow
  );
endinterface

// File: rtl/mmio_bridge.sv
// Byte-bus bridge: routes CPU accesses to RAM or I/O (UART TX FIFO, RX pop, cycle counter, stop flag).
// Optional MMIO_TX_STATS_EN adds an accepted-TX-byte counter at 0x30008 and the overflow flag at 0x3000C.
module mmio_bridge #(
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 4,
  parameter int RAM_AW      = 17
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  mmio_bridge_if.slave bus
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(TX_DEPTH);
  localparam logic [CW-1:0] FULL_THR = CW'(TX_DEPTH - FULL_MARGIN);

  typedef enum logic [3:0] {
    SEL_ZERO, SEL_RAM, SEL_RX,
    SEL_CNT0, SEL_CNT1, SEL_CNT2, SEL_CNT3,
    SEL_TXC0, SEL_TXC1, SEL_TXC2, SEL_TXC3, SEL_OVF
  } sel_t;

  sel_t          sel, sel_next;
  logic [7:0]    rx_byte;
  logic [31:0]   counter, snapshot;
  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_next;
  logic          overflow, stop_pending, finish, ibf;

  // ---------------- decode ----------------
  logic       active, is_io, io_lo, rd, wr;
  logic [3:0] off;
  logic       rd_rx, rd_cnt, wr_tx, wr_stop;
  logic       unused_a;

  assign active   = rdy_in && !rst_in;
  assign is_io    = bus.cpu_a[17:16] == 2'b11;
  assign io_lo    = bus.cpu_a[15:4] == 12'h000;
  assign off      = bus.cpu_a[3:0];
  assign rd       = active && !bus.cpu_wr;
  assign wr       = active && bus.cpu_wr;
  assign rd_rx    = rd && is_io && io_lo && (off == 4'h0);
  assign rd_cnt   = rd && is_io && io_lo && (off == 4'h4);
  assign wr_tx    = wr && is_io && io_lo && (off == 4'h0) && (bus.cpu_dout != 8'h00);
  assign wr_stop  = wr && is_io && io_lo && (off == 4'h4);
  assign unused_a = ^bus.cpu_a[31:18];

  assign bus.ram_a     = bus.cpu_a[RAM_AW-1:0];
  assign bus.ram_wdata = bus.cpu_dout;
  assign bus.ram_we    = wr && !is_io;
  assign bus.rx_pop    = rd_rx && !bus.rx_empty;

  // Read target is captured at the access so every read returns one cycle later.
  always_comb begin
    sel_next = SEL_ZERO;
    if (!bus.cpu_wr) begin
      if (!is_io) begin
        sel_next = SEL_RAM;
      end else if (io_lo) begin
        case (off)
          4'h0: sel_next = bus.rx_empty ? SEL_ZERO : SEL_RX;
          4'h4: sel_next = SEL_CNT0;
          4'h5: sel_next = SEL_CNT1;
          4'h6: sel_next = SEL_CNT2;
          4'h7: sel_next = SEL_CNT3;
`ifdef MMIO_TX_STATS_EN
          4'h8: sel_next = SEL_TXC0;
          4'h9: sel_next = SEL_TXC1;
          4'hA: sel_next = SEL_TXC2;
          4'hB: sel_next = SEL_TXC3;
          4'hC: sel_next = SEL_OVF;
`endif
          default: sel_next = SEL_ZERO;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel      <= SEL_ZERO;
      rx_byte  <= 8'h00;
      counter  <= 32'h0;
      snapshot <= 32'h0;
    end else if (rdy_in) begin
      sel     <= sel_next;
      counter <= counter + 32'h1;
      if (bus.rx_pop) rx_byte <= bus.rx_data;
      if (rd_cnt) snapshot <= counter;
    end
  end

  // ---------------- TX FIFO ----------------
  // Handshake: a byte moves on a rising edge with tx_valid && tx_ready; tx_data is the head
  // entry and stays stable until that edge. tx_valid drops while rdy_in is low (bridge frozen).
  logic empty, full, pop, push_req, push, drop;
  logic [7:0] push_data;

  assign empty     = count == '0;
  assign full      = count == DEPTH_C;
  assign pop       = active && !empty && bus.tx_ready;
  assign push_req  = wr_tx || wr_stop;
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign push_data = wr_stop ? 8'h00 : bus.cpu_dout;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[tail] <= push_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      ibf          <= 1'b0;
      overflow     <= 1'b0;
      stop_pending <= 1'b0;
      finish       <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count_next;
      ibf   <= count_next >= FULL_THR;
      if (drop)    overflow     <= 1'b1;
      if (wr_stop) stop_pending <= 1'b1;
      if (rdy_in && stop_pending && empty) finish <= 1'b1;
    end
  end

  assign bus.tx_valid       = active && !empty;
  assign bus.tx_data        = fifo_mem[head];
  assign bus.io_buffer_full = ibf;
  assign bus.program_finish = finish;
  assign bus.dbg_overflow   = overflow;

`ifdef MMIO_TX_STATS_EN
  logic [31:0] tx_acc, tx_acc_snap;
  logic        rd_stats;
  assign rd_stats = rd && is_io && io_lo && (off == 4'h8);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_acc      <= 32'h0;
      tx_acc_snap <= 32'h0;
    end else begin
      if (push)     tx_acc      <= tx_acc + 32'h1;
      if (rd_stats) tx_acc_snap <= tx_acc;
    end
  end
`endif

  // ---------------- read return ----------------
  always_comb begin
    bus.cpu_din = 8'h00;
    case (sel)
      SEL_RAM:  bus.cpu_din = bus.ram_rdata;
      SEL_RX:   bus.cpu_din = rx_byte;
      SEL_CNT0: bus.cpu_din = snapshot[7:0];
      SEL_CNT1: bus.cpu_din = snapshot[15:8];
      SEL_CNT2: bus.cpu_din = snapshot[23:16];
      SEL_CNT3: bus.cpu_din = snapshot[31:24];
`ifdef MMIO_TX_STATS_EN
      SEL_TXC0: bus.cpu_din = tx_acc_snap[7:0];
      SEL_TXC1: bus.cpu_din = tx_acc_snap[15:8];
      SEL_TXC2: bus.cpu_din = tx_acc_snap[23:16];
      SEL_TXC3: bus.cpu_din = tx_acc_snap[31:24];
      SEL_OVF:  bus.cpu_din = {7'h00, overflow};
`endif
      default:  bus.cpu_din = 8'h00;
    endcase
  end

endmodule
